// File: rtl/tone_env_pwm.sv
// Envelope-shaped PWM speaker driver: gates a square-wave tone with an ADSR-style level.
// Define ENV_SUSTAIN_DECAY_EN to make SUSTAIN slowly decay toward a floor of 128.
module tone_env_pwm #(
  parameter int unsigned ENV_STEP_DIV = 19531,
  parameter int unsigned ATTACK_STEP  = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tone_in,
  input  logic       key_on,
  output logic       pwm_out,
  output logic [7:0] env_level,
  output logic       busy
);

  // state   | meaning
  // IDLE    | silent, env_level held at 0
  // ATTACK  | key held, level rises by ATTACK_STEP per tick up to 255
  // SUSTAIN | key held at full level (optionally decaying to 128)
  // RELEASE | key released, level falls by 1 per tick down to 0
  typedef enum logic [1:0] {IDLE, ATTACK, SUSTAIN, RELEASE} state_t;

  localparam int TW = $clog2(ENV_STEP_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(ENV_STEP_DIV - 1);
  localparam logic [8:0] STEP9 = 9'(ATTACK_STEP);

  logic          tone_s1, tone_s2;
  logic          key_s1, key_s2;
  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic [7:0]    pwm_cnt;
  logic [8:0]    attack_sum;
  logic [7:0]    level_nx;
  state_t        state, state_nx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tone_s1 <= 1'b0;
      tone_s2 <= 1'b0;
      key_s1  <= 1'b0;
      key_s2  <= 1'b0;
    end else begin
      tone_s1 <= tone_in;
      tone_s2 <= tone_s1;
      key_s1  <= key_on;
      key_s2  <= key_s1;
    end
  end

  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + 1'b1;
  end

`ifdef ENV_SUSTAIN_DECAY_EN
  logic [1:0] decay_cnt;

  // Counts SUSTAIN ticks so the level drops on every fourth one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                decay_cnt <= 2'd0;
    else if (state != SUSTAIN) decay_cnt <= 2'd0;
    else if (tick)             decay_cnt <= decay_cnt + 2'd1;
  end
`endif

  assign attack_sum = {1'b0, env_level} + STEP9;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      env_level <= 8'd0;
    end else begin
      state     <= state_nx;
      env_level <= level_nx;
    end
  end

  // Key transitions are checked before ticks so a key change always wins a tie.
  always_comb begin
    state_nx = state;
    level_nx = env_level;
    case (state)
      IDLE: begin
        level_nx = 8'd0;
        if (key_s2) state_nx = ATTACK;
      end
      ATTACK: begin
        if (!key_s2) begin
          state_nx = RELEASE;
        end else if (tick) begin
          if (attack_sum >= 9'd255) begin
            level_nx = 8'd255;
            state_nx = SUSTAIN;
          end else begin
            level_nx = attack_sum[7:0];
          end
        end
      end
      SUSTAIN: begin
        if (!key_s2) state_nx = RELEASE;
`ifdef ENV_SUSTAIN_DECAY_EN
        else if (tick && (decay_cnt == 2'd3) && (env_level > 8'd128))
          level_nx = env_level - 8'd1;
`endif
      end
      RELEASE: begin
        if (key_s2) begin
          state_nx = ATTACK;
        end else if (tick) begin
          if (env_level <= 8'd1) begin
            level_nx = 8'd0;
            state_nx = IDLE;
          end else begin
            level_nx = env_level - 8'd1;
          end
        end
      end
      default: begin
        state_nx = IDLE;
        level_nx = 8'd0;
      end
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pwm_cnt <= 8'd0;
      pwm_out <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 8'd1;
      pwm_out <= tone_s2 & (pwm_cnt < env_level);
    end
  end

endmodule

// File: tb/tb_tone_env_pwm.sv
// Self-checking bench for tone_env_pwm: directed scenarios plus randomized key/tone
// traffic compared cycle by cycle against a behavioural envelope model.
module tb_tone_env_pwm;
  localparam int DIV  = 4;
  localparam int STEP = 64;
  localparam int DIV2 = 1000;
  localparam int M_IDLE = 0, M_ATT = 1, M_SUS = 2, M_REL = 3;

  logic       clk = 1'b0, reset = 1'b0;
  logic       tone_in = 1'b0, key_on = 1'b0, tone2 = 1'b0, key2 = 1'b0;
  logic       pwm_out, busy, pwm2, busy2;
  logic [7:0] env_level, env2;

  int n_checks = 0, n_fail = 0;

  int m_cyc, m_level, m_mode, m_sus;
  bit m_k1, m_k2, m_t1, m_t2, m_pwm;

  always #5 clk = ~clk;

  tone_env_pwm #(.ENV_STEP_DIV(DIV), .ATTACK_STEP(STEP)) dut (
    .clk(clk), .reset(reset), .tone_in(tone_in), .key_on(key_on),
    .pwm_out(pwm_out), .env_level(env_level), .busy(busy));

  tone_env_pwm #(.ENV_STEP_DIV(DIV2), .ATTACK_STEP(STEP)) dut2 (
    .clk(clk), .reset(reset), .tone_in(tone2), .key_on(key2),
    .pwm_out(pwm2), .env_level(env2), .busy(busy2));

  task automatic model_clear();
    m_cyc = 0; m_level = 0; m_mode = M_IDLE; m_sus = 0;
    m_k1 = 0; m_k2 = 0; m_t1 = 0; m_t2 = 0; m_pwm = 0;
  endtask

  // Advance one clock: the model sees the same inputs the DUT samples at the edge.
  task automatic step();
    bit tick;
    @(posedge clk);
    tick  = (m_cyc % DIV) == DIV - 1;
    m_pwm = m_t2 && ((m_cyc % 256) < m_level);
    case (m_mode)
      M_IDLE: if (m_k2) m_mode = M_ATT;
      M_ATT: begin
        if (!m_k2) m_mode = M_REL;
        else if (tick) begin
          m_level = m_level + STEP;
          if (m_level >= 255) begin m_level = 255; m_mode = M_SUS; m_sus = 0; end
        end
      end
      M_SUS: begin
        if (!m_k2) m_mode = M_REL;
        else if (tick) begin
`ifdef ENV_SUSTAIN_DECAY_EN
          m_sus = m_sus + 1;
          if ((m_sus % 4) == 0 && m_level > 128) m_level = m_level - 1;
`endif
        end
      end
      default: begin
        if (m_k2) m_mode = M_ATT;
        else if (tick) begin
          m_level = m_level - 1;
          if (m_level <= 0) begin m_level = 0; m_mode = M_IDLE; end
        end
      end
    endcase
    m_cyc = m_cyc + 1;
    m_k2 = m_k1; m_k1 = key_on;
    m_t2 = m_t1; m_t1 = tone_in;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    key_on = 1'b1; tone_in = 1'b1; reset = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    n_checks += 3;
    if (env_level !== 8'd0) begin n_fail++; $display("FAIL reset_env: got %0d expected 0", env_level); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    if (pwm_out !== 1'b0) begin n_fail++; $display("FAIL reset_pwm: got %b expected 0", pwm_out); end
    key_on = 1'b0; tone_in = 1'b0;
    reset = 1'b1;
    repeat (6) begin
      step();
      n_checks += 2;
      if (env_level !== 8'(m_level)) begin n_fail++; $display("FAIL reset_idle_env: got %0d expected %0d", env_level, m_level); end
      if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy: got %b expected 0", busy); end
    end
  endtask

  task automatic test_attack();
    int exp_q[$];
    int got_q[$];
    int lvl, prev;
    lvl = 0;
    while (lvl < 255) begin
      lvl = (lvl + STEP > 255) ? 255 : lvl + STEP;
      exp_q.push_back(lvl);
    end
    tone_in = 1'b1; key_on = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      step();
      n_checks++;
      if (busy !== (e == 3)) begin n_fail++; $display("FAIL attack_latency edge%0d: busy=%b expected %b", e, busy, e == 3); end
    end
    prev = env_level;
    for (int i = 0; i < 10 * DIV && (got_q.size() == 0 || got_q[$] != 255); i++) begin
      step();
      n_checks += 2;
      if (env_level !== 8'(m_level)) begin n_fail++; $display("FAIL attack_env: got %0d expected %0d", env_level, m_level); end
      if (pwm_out !== m_pwm) begin n_fail++; $display("FAIL attack_pwm: got %b expected %b", pwm_out, m_pwm); end
      if (int'(env_level) != prev) begin got_q.push_back(int'(env_level)); prev = env_level; end
    end
    n_checks++;
    if (got_q != exp_q) begin n_fail++; $display("FAIL attack_steps: got %p expected %p", got_q, exp_q); end
  endtask

  task automatic test_sustain();
`ifdef ENV_SUSTAIN_DECAY_EN
    int steps;
    steps = 0;
    while (env_level != 8'd128 && steps < 520 * DIV) begin
      step();
      steps++;
      n_checks++;
      if (env_level !== 8'(m_level)) begin n_fail++; $display("FAIL decay_env: got %0d expected %0d", env_level, m_level); end
    end
    n_checks++;
    if (steps < 507 * DIV || steps > 508 * DIV) begin n_fail++; $display("FAIL decay_time: got %0d cycles expected about %0d", steps, 508 * DIV); end
    repeat (20 * DIV) begin
      step();
      n_checks++;
      if (env_level !== 8'd128) begin n_fail++; $display("FAIL decay_floor: got %0d expected 128", env_level); end
    end
`else
    repeat (20 * DIV) begin
      step();
      n_checks += 2;
      if (env_level !== 8'd255) begin n_fail++; $display("FAIL sustain_hold: got %0d expected 255", env_level); end
      if (busy !== 1'b1) begin n_fail++; $display("FAIL sustain_busy: got %b expected 1", busy); end
    end
`endif
  endtask

  task automatic test_release();
    int start, n_dec, prev;
    start = m_level; n_dec = 0; prev = env_level;
    key_on = 1'b0;
    for (int i = 0; i < (start + 4) * DIV; i++) begin
      step();
      n_checks += 2;
      if (env_level !== 8'(m_level)) begin n_fail++; $display("FAIL release_env: got %0d expected %0d", env_level, m_level); end
      if (busy !== (env_level != 8'd0)) begin n_fail++; $display("FAIL release_busy: busy=%b with level %0d", busy, env_level); end
      if (int'(env_level) != prev) begin
        n_checks++;
        if (int'(env_level) != prev - 1) begin n_fail++; $display("FAIL release_step: got %0d expected %0d", env_level, prev - 1); end
        n_dec++; prev = env_level;
      end
      if (busy == 1'b0) break;
    end
    n_checks += 2;
    if (n_dec != start) begin n_fail++; $display("FAIL release_count: got %0d decrements expected %0d", n_dec, start); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL release_idle: busy=%b expected 0", busy); end
  endtask

  task automatic test_resume();
    int guard;
    key_on = 1'b1;
    guard = 0;
    while (env_level != 8'd255 && guard < 12 * DIV) begin step(); guard++; end
    key_on = 1'b0;
    guard = 0;
    while (env_level != 8'd100 && guard < 200 * DIV) begin step(); guard++; end
    n_checks++;
    if (env_level !== 8'd100) begin n_fail++; $display("FAIL resume_reach100: got %0d expected 100", env_level); end
    key_on = 1'b1;
    guard = 0;
    while (env_level == 8'd100 && guard < 3 * DIV) begin step(); guard++; end
    n_checks += 2;
    if (env_level !== 8'd164) begin n_fail++; $display("FAIL resume_level: got %0d expected 164", env_level); end
    if (env_level !== 8'(m_level)) begin n_fail++; $display("FAIL resume_model: got %0d expected %0d", env_level, m_level); end
  endtask

  task automatic test_pwm();
    int guard, highs;
    tone2 = 1'b1; key2 = 1'b1;
    guard = 0;
    while (env2 != 8'd64 && guard < 2 * DIV2) begin @(negedge clk); guard++; end
    n_checks += 2;
    if (env2 !== 8'd64) begin n_fail++; $display("FAIL pwm_level: got %0d expected 64", env2); end
    if (busy2 !== 1'b1) begin n_fail++; $display("FAIL pwm_busy: got %b expected 1", busy2); end
    @(negedge clk);
    highs = 0;
    repeat (256) begin highs += int'(pwm2); @(negedge clk); end
    n_checks++;
    if (highs != 64) begin n_fail++; $display("FAIL pwm_duty64: got %0d high cycles expected 64", highs); end
    tone2 = 1'b0;
    repeat (3) @(negedge clk);
    highs = 0;
    repeat (256) begin highs += int'(pwm2); @(negedge clk); end
    n_checks++;
    if (highs != 0) begin n_fail++; $display("FAIL pwm_tone_off: got %0d high cycles expected 0", highs); end
    key2 = 1'b0;
  endtask

  task automatic test_reset_mid_attack();
    int guard;
    key_on = 1'b0; tone_in = 1'b1;
    do_reset();
    key_on = 1'b1;
    guard = 0;
    while (env_level != 8'd128 && guard < 20 * DIV) begin step(); guard++; end
    n_checks++;
    if (env_level !== 8'd128) begin n_fail++; $display("FAIL midreset_reach: got %0d expected 128", env_level); end
    #2 reset = 1'b0;
    #1;
    n_checks += 3;
    if (env_level !== 8'd0) begin n_fail++; $display("FAIL midreset_env: got %0d expected 0", env_level); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b expected 0", busy); end
    if (pwm_out !== 1'b0) begin n_fail++; $display("FAIL midreset_pwm: got %b expected 0", pwm_out); end
    model_clear();
    @(negedge clk);
    reset = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      step();
      n_checks++;
      if (busy !== (e == 3)) begin n_fail++; $display("FAIL midreset_restart edge%0d: busy=%b expected %b", e, busy, e == 3); end
    end
    guard = 0;
    while (env_level == 8'd0 && guard < 3 * DIV) begin step(); guard++; end
    n_checks++;
    if (env_level !== 8'd64) begin n_fail++; $display("FAIL midreset_from0: got %0d expected 64", env_level); end
  endtask

  task automatic test_random();
    int left;
    left = 4000;
    while (left > 0) begin
      int hold;
      key_on  = 1'($urandom_range(0, 1));
      tone_in = 1'($urandom_range(0, 1));
      hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : int'($urandom_range(20, 700));
      for (int i = 0; i < hold && left > 0; i++) begin
        step();
        left--;
        n_checks += 3;
        if (env_level !== 8'(m_level)) begin n_fail++; $display("FAIL rnd_env: got %0d expected %0d", env_level, m_level); end
        if (busy !== 1'(m_mode != M_IDLE)) begin n_fail++; $display("FAIL rnd_busy: got %b expected %b", busy, m_mode != M_IDLE); end
        if (pwm_out !== m_pwm) begin n_fail++; $display("FAIL rnd_pwm: got %b expected %b", pwm_out, m_pwm); end
      end
    end
  endtask

  initial begin
    model_clear();
    @(negedge clk);
    test_reset();
    test_attack();
    test_sustain();
    test_release();
    test_resume();
    test_pwm();
    test_reset_mid_attack();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tone_env_pwm.md
TONE_ENV_PWM -- requirements
Module: tone_env_pwm

Interface
REQ-001 Parameter ENV_STEP_DIV, default 19531, clk cycles per envelope tick (50 MHz -> ~2560 ticks/s); legal range 2..2^20.
REQ-002 Parameter ATTACK_STEP, default 1, level increment per attack tick; legal range 1..255.
REQ-003 Port clk  input  1  system clock, 50 MHz, rising-edge.
REQ-004 Port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 Port tone_in  input  1  square-wave note from an upstream note generator; treated as asynchronous.
REQ-006 Port key_on  input  1  debounced key-held level; treated as asynchronous.
REQ-007 Port pwm_out  output  1  registered PWM speaker drive.
REQ-008 Port env_level  output  8  current envelope level, registered.
REQ-009 Port busy  output  1  high whenever state is not IDLE.

Function
REQ-010 tone_in and key_on SHALL each pass through a 2-flop synchronizer; only synced values are used internally.
REQ-011 Tick counter SHALL be free-running 0..ENV_STEP_DIV-1, wrapping to 0; tick pulses one cycle when counter equals ENV_STEP_DIV-1.
REQ-012 State machine SHALL have states IDLE, ATTACK, SUSTAIN, RELEASE.
REQ-013 IDLE: env_level held at 0; synced key_on=1 -> ATTACK on the next edge.
REQ-014 ATTACK: on each tick env_level += ATTACK_STEP, computed 9-bit and saturated to 255; reaching 255 -> SUSTAIN in the same update.
REQ-015 SUSTAIN: env_level held (see REQ-025).
REQ-016 ATTACK or SUSTAIN with synced key_on=0 -> RELEASE on the next edge, regardless of tick; env_level unchanged by the transition.
REQ-017 RELEASE: on each tick env_level -= 1; reaching 0 -> IDLE in the same update.
REQ-018 RELEASE with synced key_on=1 -> ATTACK from the current env_level (no restart from 0).
REQ-019 Simultaneous tick and key_on change in one cycle: the key transition wins; no level update that cycle.
REQ-020 Latency: key_on change reflected in busy/state 3 clk edges after the input changes (2 sync + 1 state register).
REQ-021 PWM counter SHALL be 8-bit free-running, wrapping 255 -> 0.
REQ-022 pwm_out SHALL be registered as (synced tone_in AND pwm_cnt < env_level); tone_in to pwm_out latency is 3 edges.
REQ-023 env_level=0 gives pwm_out constantly 0; env_level=255 gives a 255/256 duty cycle while synced tone_in=1.

Reset
REQ-024 reset=0 SHALL immediately clear synchronizers, tick counter, PWM counter, env_level=0, pwm_out=0, busy=0 and state=IDLE, including mid-ATTACK or mid-RELEASE; operation resumes on the first clk edge after reset returns to 1.

Configuration
REQ-025 Macro ENV_SUSTAIN_DECAY_EN: when defined, SUSTAIN decrements env_level by 1 every 4th tick down to a floor of 128, then holds at 128; when undefined, SUSTAIN holds env_level unchanged and the decay divider logic is absent.

Verification
REQ-026 ENV_STEP_DIV=4, ATTACK_STEP=64, tone_in=1, key_on 0->1 -> busy=1 after 3 edges; env_level steps 64, 128, 192, 255 on successive ticks; state SUSTAIN.
REQ-027 In SUSTAIN at 255, key_on 1->0 -> RELEASE; env_level decrements by 1 every 4 cycles to 0 after 255 ticks; busy=0 and state IDLE at the same update.
REQ-028 In RELEASE at env_level=100, key_on 0->1 -> ATTACK resumes from 100; the next tick gives 164 with ATTACK_STEP=64.
REQ-029 env_level forced to 64, tone_in=1 -> pwm_out high for exactly 64 of every 256 cycles; tone_in=0 -> pwm_out=0 for all 256.
REQ-030 reset pulsed low mid-ATTACK at env_level=128 -> env_level, pwm_out and busy go to 0 without a clock edge; key_on still 1 after release restarts ATTACK from 0.
REQ-031 With ENV_SUSTAIN_DECAY_EN defined, ENV_STEP_DIV=4: SUSTAIN at 255 -> env_level reaches 128 after 508 ticks and stays 128 with key_on=1.
